// File: rtl/spart_pkg.sv
// Shared SPART definitions: bus register addresses, baud presets and oversample ratio.
package spart_pkg;

    localparam logic [1:0] ADDR_DB_LO = 2'b10;
    localparam logic [1:0] ADDR_DB_HI = 2'b11;

    localparam int unsigned OVERSAMPLE = 16;

    // Divisors for a 25 MHz clock with 16x oversampling
    localparam logic [15:0] DB_4800  = 16'h0144;
    localparam logic [15:0] DB_9600  = 16'h00A1;
    localparam logic [15:0] DB_19200 = 16'h0050;
    localparam logic [15:0] DB_38400 = 16'h0027;

    typedef enum logic [1:0] {
        BrCfg4800  = 2'b00,
        BrCfg9600  = 2'b01,
        BrCfg19200 = 2'b10,
        BrCfg38400 = 2'b11
    } br_cfg_t;

    function automatic logic [15:0] br_preset(input br_cfg_t cfg);
        logic [15:0] val;
        unique case (cfg)
            BrCfg4800:  val = DB_4800;
            BrCfg9600:  val = DB_9600;
            BrCfg19200: val = DB_19200;
            BrCfg38400: val = DB_38400;
            default:    val = DB_9600;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/spart_div_cnt.sv
// Reloadable down-counter: counts load_val..0, then reloads from reload_val and emits a
// registered one-cycle terminal-count pulse. An explicit load suppresses that expiry.
module spart_div_cnt #(
    parameter int unsigned   W         = 16,
    parameter logic [W-1:0]  RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] reload_val,
    output logic         expire,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tc_q, tc_d;

    always_comb begin
        expire = (cnt_q == '0) && !load;
        cnt_d  = cnt_q - W'(1);
        tc_d   = 1'b0;
        if (load) begin
            cnt_d = load_val;
        end else if (expire) begin
            cnt_d = reload_val;
            tc_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= RESET_VAL;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign tc = tc_q;

endmodule

// File: rtl/spart_baud_gen.sv
// SPART baud-rate generator: bus-loadable divisor, 16x rx enable and 1x tx enable.
// Define SPART_BR_PRESET_EN to let br_cfg changes load one of four preset divisors.
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter int unsigned       DIV_W    = 16,
    parameter logic [DIV_W-1:0]  DB_RESET = DIV_W'(16'h00A1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       br_cfg,
    input  logic             iocs,
    input  logic             iorw,
    input  logic [1:0]       ioaddr,
    input  logic [7:0]       wdata,
    output logic             rx_en,
    output logic             tx_en,
    output logic [DIV_W-1:0] db
);

    localparam int unsigned          PHASE_W    = $clog2(OVERSAMPLE);
    localparam logic [PHASE_W-1:0]   PHASE_LAST = PHASE_W'(OVERSAMPLE - 1);

    logic             wr_lo, wr_hi;
    logic [7:0]       db_lo_stage_q, db_lo_stage_d;
    logic [DIV_W-1:0] db_q, db_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic             tx_q, tx_d;
    logic             preset_ld;
    logic [DIV_W-1:0] preset_val;
    logic             load;
    logic [DIV_W-1:0] load_val;
    logic             expire;

    assign wr_lo = iocs && !iorw && (ioaddr == ADDR_DB_LO);
    assign wr_hi = iocs && !iorw && (ioaddr == ADDR_DB_HI);

`ifdef SPART_BR_PRESET_EN
    logic [1:0] br_cfg_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cfg_q <= BrCfg9600;
        end else begin
            br_cfg_q <= br_cfg;
        end
    end

    assign preset_ld  = (br_cfg != br_cfg_q);
    assign preset_val = DIV_W'(br_preset(br_cfg_t'(br_cfg)));
`else
    logic unused_br_cfg;

    assign unused_br_cfg = ^br_cfg;
    assign preset_ld     = 1'b0;
    assign preset_val    = '0;
`endif

    // A bus high-byte write outranks a simultaneous preset change
    assign load     = wr_hi || preset_ld;
    assign load_val = wr_hi ? DIV_W'({wdata, db_lo_stage_q}) : preset_val;

    spart_div_cnt #(
        .W         (DIV_W),
        .RESET_VAL (DB_RESET)
    ) u_div_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_val   (load_val),
        .reload_val (db_q),
        .expire     (expire),
        .tc         (rx_en)
    );

    always_comb begin
        db_lo_stage_d = db_lo_stage_q;
        db_d          = db_q;
        phase_d       = phase_q;
        tx_d          = 1'b0;
        if (wr_lo) begin
            db_lo_stage_d = wdata;
        end
        if (load) begin
            db_d    = load_val;
            phase_d = '0;
        end else if (expire) begin
            phase_d = phase_q + PHASE_W'(1);
            tx_d    = (phase_q == PHASE_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_lo_stage_q <= 8'h00;
            db_q          <= DB_RESET;
            phase_q       <= '0;
            tx_q          <= 1'b0;
        end else begin
            db_lo_stage_q <= db_lo_stage_d;
            db_q          <= db_d;
            phase_q       <= phase_d;
            tx_q          <= tx_d;
        end
    end

    assign tx_en = tx_q;
    assign db    = db_q;

    tx_implies_rx: assert property (@(posedge clk) disable iff (!rst) tx_en |-> rx_en);

endmodule

// File: tb/tb_spart_baud_gen.sv
// Self-checking bench for spart_baud_gen: table vectors, corner sequences and random bus
// traffic, all compared cycle by cycle against an arithmetic timing model.
module tb_spart_baud_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  br_cfg = 2'b01;
    logic        iocs = 1'b0;
    logic        iorw = 1'b1;
    logic [1:0]  ioaddr = 2'b00;
    logic [7:0]  wdata = 8'h00;
    logic        rx_en;
    logic        tx_en;
    logic [15:0] db;

    int checks = 0;
    int errors = 0;

    // Model: rx_en fires every (d+1) edges after the last load edge, tx_en on every 16th
    int         e;
    int         m_l;
    int         m_d;
    logic [7:0] m_stage;
    logic [1:0] m_brq;
    logic       exp_rx;
    logic       exp_tx;

    spart_baud_gen dut (
        .clk    (clk),
        .rst    (rst),
        .br_cfg (br_cfg),
        .iocs   (iocs),
        .iorw   (iorw),
        .ioaddr (ioaddr),
        .wdata  (wdata),
        .rx_en  (rx_en),
        .tx_en  (tx_en),
        .db     (db)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] exp_db;
        int          exp_period;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
        end
    endtask

    function automatic int preset_of(input logic [1:0] c);
        case (c)
            2'b00:   return 'h0144;
            2'b01:   return 'h00A1;
            2'b10:   return 'h0050;
            default: return 'h0027;
        endcase
    endfunction

    task automatic model_reset();
        e       = 0;
        m_l     = 0;
        m_d     = 161;
        m_stage = 8'h00;
        m_brq   = 2'b01;
        exp_rx  = 1'b0;
        exp_tx  = 1'b0;
    endtask

    task automatic model_edge();
        bit hi, lo;
        hi = iocs && !iorw && (ioaddr == 2'b11);
        lo = iocs && !iorw && (ioaddr == 2'b10);
        e++;
        if (hi) begin
            m_l = e;
            m_d = int'({wdata, m_stage});
        end
`ifdef SPART_BR_PRESET_EN
        else if (br_cfg != m_brq) begin
            m_l = e;
            m_d = preset_of(br_cfg);
        end
        m_brq = br_cfg;
`endif
        if (lo) m_stage = wdata;
        exp_rx = (e > m_l) && (((e - m_l) % (m_d + 1)) == 0);
        exp_tx = exp_rx && ((((e - m_l) / (m_d + 1)) % 16) == 0);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("rx_en", int'(rx_en), int'(exp_rx));
        check("tx_en", int'(tx_en), int'(exp_tx));
        check("db", int'(db), m_d);
    endtask

    task automatic bus_wr(input logic [1:0] addr, input logic [7:0] data);
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = addr;
        wdata  = data;
        tick();
        iocs   = 1'b0;
        iorw   = 1'b1;
        ioaddr = 2'b00;
        wdata  = 8'h00;
    endtask

    // Ticks until rx_en (sel 0) or tx_en (sel 1) is seen; n = -1 on timeout
    task automatic wait_for(input int sel, input int max, output int n);
        n = 0;
        while (n < max) begin
            tick();
            n++;
            if ((sel == 0 && rx_en) || (sel == 1 && tx_en)) return;
        end
        n = -1;
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        check({tag, "_rx"}, int'(rx_en), 0);
        check({tag, "_tx"}, int'(tx_en), 0);
        check({tag, "_db"}, int'(db), 'h00A1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2;

        vecs[0] = '{lo: 8'h04, hi: 8'h00, exp_db: 16'h0004, exp_period: 5};
        vecs[1] = '{lo: 8'h10, hi: 8'h00, exp_db: 16'h0010, exp_period: 17};
        vecs[2] = '{lo: 8'h00, hi: 8'h00, exp_db: 16'h0000, exp_period: 1};
        vecs[3] = '{lo: 8'hFF, hi: 8'h00, exp_db: 16'h00FF, exp_period: 256};
        vecs[4] = '{lo: 8'h00, hi: 8'h01, exp_db: 16'h0100, exp_period: 257};
        vecs[5] = '{lo: 8'h07, hi: 8'h00, exp_db: 16'h0007, exp_period: 8};

        do_reset("reset");

        // Default divisor after reset
        wait_for(0, 400, n);
        check("first_rx_after_reset", n, 162);
        wait_for(1, 3000, n2);
        check("first_tx_after_reset", (n2 < 0) ? -1 : n + n2, 2592);

        // Reset mid-count, then the full first period again
        repeat (70) tick();
        do_reset("midreset");
        wait_for(0, 400, n);
        check("rx_after_midreset", n, 162);

        foreach (vecs[i]) begin
            bus_wr(2'b10, vecs[i].lo);
            bus_wr(2'b11, vecs[i].hi);
            check("tbl_db", int'(db), int'(vecs[i].exp_db));
            wait_for(0, 2000, n);
            check("tbl_period", n, vecs[i].exp_period);
        end

        // Low-byte write alone leaves the active period untouched
        do_reset("reset2");
        bus_wr(2'b10, 8'h10);
        wait_for(0, 400, n);
        wait_for(0, 400, n);
        check("lo_only_period", n, 162);
        bus_wr(2'b11, 8'h00);
        wait_for(0, 100, n);
        check("lo_then_hi_period", n, 17);

        // tx_en every 80 clocks for db = 4
        bus_wr(2'b10, 8'h04);
        bus_wr(2'b11, 8'h00);
        wait_for(1, 200, n);
        check("tx_first_db4", n, 80);
        wait_for(1, 200, n);
        check("tx_period_db4", n, 80);

        // db = 0: rx_en continuous, tx_en every 16, then reset while rx_en is high
        bus_wr(2'b10, 8'h00);
        bus_wr(2'b11, 8'h00);
        repeat (20) tick();
        wait_for(1, 40, n);
        wait_for(1, 40, n);
        check("tx_period_db0", n, 16);
        check("rx_high_db0", int'(rx_en), 1);
        do_reset("db0_reset");

        // High-byte write on the cycle the counter sits at zero
        bus_wr(2'b10, 8'h04);
        bus_wr(2'b11, 8'h00);
        wait_for(0, 20, n);
        bus_wr(2'b10, 8'h09);
        repeat (3) tick();
        bus_wr(2'b11, 8'h00);
        check("hi_on_tc_no_rx", int'(rx_en), 0);
        wait_for(0, 40, n);
        check("hi_on_tc_next_rx", n, 10);

`ifdef SPART_BR_PRESET_EN
        br_cfg = 2'b11;
        tick();
        check("preset_db", int'(db), 'h0027);
        wait_for(0, 100, n);
        check("preset_period", n, 40);
        bus_wr(2'b10, 8'h00);
        br_cfg = 2'b00;
        bus_wr(2'b11, 8'h01);
        check("preset_vs_hi_db", int'(db), 'h0100);
        wait_for(0, 400, n);
        check("preset_vs_hi_period", n, 257);
`endif

        // Random bus traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if (($urandom % 16) == 0) begin
                iocs   = ($urandom % 4) != 0;
                iorw   = ($urandom % 4) == 0;
                ioaddr = 2'($urandom % 4);
                wdata  = (ioaddr == 2'b11) ? ((($urandom % 3) == 0) ? 8'h01 : 8'h00)
                                           : 8'($urandom % 256);
            end else begin
                iocs   = 1'b0;
                iorw   = 1'b1;
                ioaddr = 2'b00;
                wdata  = 8'h00;
            end
`ifdef SPART_BR_PRESET_EN
            if (($urandom % 300) == 0) br_cfg = 2'($urandom % 4);
`endif
            tick();
        end
        iocs = 1'b0;
        iorw = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spart_baud_gen.md
# spart_baud_gen

Programmable baud-rate generator for the SPART. It holds the 16-bit division buffer (DB), which the processor bus interface loads through `ioaddr` 2'b10 (low byte) and 2'b11 (high byte). From DB it produces a 16x-oversample enable for the receiver and a 1x bit enable for the transmitter. It sits directly upstream of `spart_rx` and `spart_tx`, and is the only source of their timing.

## Interface
Parameters:
- `DIV_W`, 16: width of the divisor and down-counter.
- `DB_RESET`, 16'h00A1: active divisor after reset (9600 baud at 25 MHz, 16x).

Ports:
- `clk` in 1: system clock, 25 MHz nominal.
- `rst` in 1: reset; one clock, asynchronous, active-low.
- `br_cfg` in 2: baud preset select.
- `iocs` in 1: chip select.
- `iorw` in 1: 0 = write, 1 = read. Reads are ignored by this block.
- `ioaddr` in 2: register address.
- `wdata` in 8: write data, the bus-interface copy of `databus`.
- `rx_en` out 1: 16x sample enable, one-cycle pulse.
- `tx_en` out 1: bit enable, one-cycle pulse, coincident with every 16th `rx_en`.
- `db` out 16: active divisor, for debug and readback mux.

## Operation
Registers:
- `db_lo_stage`, 8 bits.
- `db` (active divisor).
- `cnt` (down-counter).
- `phase`, 4 bits.
- `br_cfg_q`.

Low-byte write (`iocs && !iorw && ioaddr==2'b10`):
- Writes `db_lo_stage`.
- Active `db` unchanged.

High-byte write (`iocs && !iorw && ioaddr==2'b11`):
- `db <= {wdata, db_lo_stage}`.
- `cnt <= {wdata, db_lo_stage}`.
- `phase <= 0`.
- Generator restarts.

Addresses 2'b00/2'b01, and all reads: no effect.

Counting:
- `cnt` decrements each clock.
- When `cnt==0`: `rx_en` pulses the next cycle, `cnt` reloads from `db`, and `phase` increments (wraps 15→0).
- `tx_en` pulses with `rx_en` when `phase` was 15 before the increment.

Arithmetic and boundaries:
- `rx_en` period is `db+1` clocks; `tx_en` period is `16*(db+1)`.
- `db==0`: `rx_en` high every cycle, `tx_en` every 16 cycles.
- Unsigned, no saturation; counter wrap is prevented by the reload at 0.
- High-byte write on the same cycle `cnt` hits 0: the write wins; no `rx_en` pulse is issued for that expiry.

Reset values:
- `rx_en`=0, `tx_en`=0, `db`=`DB_RESET`, `cnt`=`DB_RESET`, `phase`=0, `db_lo_stage`=0, `br_cfg_q`=2'b01.
- Reset asserted mid-count: all of the above are restored immediately, with no partial pulse.

## Timing
- `rx_en` and `tx_en` are registered.
- First `rx_en` after a high-byte write: write edge + `db+1` clocks, with a one-cycle pulse width.
- First `rx_en` after reset release: `DB_RESET+1` clocks.
- No other handshake: writes take effect on the clock edge where they are decoded, and `iocs` may stay high across consecutive writes.
- Preset reload (with the macro defined) completes one clock after `br_cfg` changes.

## Configuration
Macro: `SPART_BR_PRESET_EN`.

Defined:
- `br_cfg` is registered into `br_cfg_q`.
- Any cycle where `br_cfg != br_cfg_q` loads `db` and `cnt` with a preset and clears `phase`.
- Presets: 00→16'h0144 (4800), 01→16'h00A1 (9600), 10→16'h0050 (19200), 11→16'h0027 (38400).
- A high-byte write on the same cycle takes priority over the preset load; `br_cfg_q` still updates.

Undefined:
- `br_cfg` is ignored and `br_cfg_q` is removed.
- The divisor changes only through bus writes.

## Structure
- Shared package `spart_pkg` holds:
  - `ADDR_DB_LO`=2'b10 and `ADDR_DB_HI`=2'b11.
  - The four preset constants.
  - A `br_cfg_t` enum.
  - `OVERSAMPLE`=16.
- One natural sub-module: `spart_div_cnt`, the reloadable down-counter with terminal-count pulse. It is instantiated once for the 16x enable; the /16 phase stays inline.

## Test plan
- Reset, no writes: first `rx_en` 162 clocks after release; `tx_en` on the 16th `rx_en` (2592 clocks); `db`=16'h00A1.
- Write 10→8'h04, then 11→8'h00: `rx_en` every 5 clocks from the write edge, `tx_en` every 80; `db`=16'h0004.
- Low-byte write only (8'h10): `rx_en` period unchanged at 162; a following high write of 8'h00 makes the period 17.
- Write DB=16'h0000: `rx_en` continuously high, `tx_en` every 16 clocks; `rx_en`/`tx_en` return to 0 the instant `rst` is pulled low mid-count.
- With `SPART_BR_PRESET_EN`: `br_cfg` 01→11 gives `db`=16'h0027 one clock later and `rx_en` period 40. A `br_cfg` change on the same cycle as a high write of 8'h01 (low stage 8'h00) gives `db`=16'h0100.
- High-byte write landing on the `cnt==0` cycle: no `rx_en` that cycle; next `rx_en` at write + new `db`+1.
